aes256_enc_out_serializer: RTL and testbench

//  Downstream stage of the AES-256 encryptor: captures each 128-bit encData block on the done rising edge.

---
 rtl/aes256_enc_out_serializer_pkg.sv | 15 +
 rtl/aes256_enc_out_serializer_if.sv | 32 +++
 rtl/aes256_enc_out_serializer_fifo.sv | 53 +++++
 rtl/aes256_enc_out_serializer.sv | 124 ++++++++++++
 tb/tb_aes256_enc_out_serializer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes256_enc_out_serializer_pkg.sv
// Shared types and sizes for the AES-256 output serializer slice.
package aes256_enc_out_serializer_pkg;

  localparam int AES_N       = 16;
  localparam int AES_BLOCK_W = 8 * AES_N;
  localparam int AXI_WORD_W  = 32;

  typedef logic [AES_N-1:0][7:0] aes_block_t;

  typedef enum logic {
    SER_IDLE,
    SER_SEND
  } ser_state_t;

endpackage

// File: rtl/aes256_enc_out_serializer_if.sv
// Block capture input (encData/done) and 32-bit word stream (dout valid/ready/last).
// The serializer is the master: it consumes the block side and drives the word side.
interface aes256_enc_out_serializer_if
  import aes256_enc_out_serializer_pkg::*;
();

  aes_block_t              encData;
  logic                    done;
  logic [AXI_WORD_W-1:0]   dout;
  logic                    dout_valid;
  logic                    dout_ready;
  logic                    dout_last;

  modport master (
    input  encData,
    input  done,
    input  dout_ready,
    output dout,
    output dout_valid,
    output dout_last
  );

  modport slave (
    output encData,
    output done,
    output dout_ready,
    input  dout,
    input  dout_valid,
    input  dout_last
  );

endinterface

// File: rtl/aes256_enc_out_serializer_fifo.sv
// Small block FIFO with a registered occupancy count.
// A push while full is legal only together with a pop; the caller gates it.
module aes256_enc_out_serializer_fifo
  import aes256_enc_out_serializer_pkg::*;
#(
  parameter int W     = AES_BLOCK_W,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_pop,
  output logic [W-1:0] o_rd_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Storage has no reset; only entries below r_count are ever read.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);

endmodule

// File: rtl/aes256_enc_out_serializer.sv
// Captures AES ciphertext blocks on the rising edge of done, buffers them and
// streams each block out as four 32-bit words, most significant word first.
//
// state    | meaning
// SER_IDLE | no block loaded; loads the FIFO head when one is present
// SER_SEND | shift register holds a block; presenting word r_idx on dout
module aes256_enc_out_serializer
  import aes256_enc_out_serializer_pkg::*;
#(
  parameter int N      = AES_N,
  parameter int WORD_W = AXI_WORD_W,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  aes256_enc_out_serializer_if.master       bus,
  input  logic                              clr_overflow,
  output logic                              busy,
  output logic                              overflow,
  output logic [CNT_W-1:0]                  blocks_sent
);

  localparam int BLOCK_W = 8 * N;
  localparam int WORDS   = BLOCK_W / WORD_W;
  localparam int IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  ser_state_t          r_state;
  logic [BLOCK_W-1:0]  r_sreg;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_blocks_sent;
  logic                r_overflow;
  logic                r_done_q;

  logic                w_push_req;
  logic                w_push;
  logic                w_pop;
  logic                w_drop;
  logic                w_last_xfer;
  logic                w_full;
  logic                w_empty;
  logic [BLOCK_W-1:0]  w_rd_data;

  assign w_push_req  = bus.done & ~r_done_q;
  assign w_last_xfer = (r_state == SER_SEND) & bus.dout_ready & (r_idx == LAST_IDX);
  // Pop decisions use the registered FIFO count, so a block pushed this cycle
  // is never popped in the same cycle.
  assign w_pop  = ~w_empty & ((r_state == SER_IDLE) | w_last_xfer);
  assign w_push = w_push_req & (~w_full | w_pop);
  assign w_drop = w_push_req & w_full & ~w_pop;

  aes256_enc_out_serializer_fifo #(
    .W     (BLOCK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_wr_data (bus.encData),
    .i_pop     (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Delayed done for rising-edge capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_done_q <= 1'b0;
    else       r_done_q <= bus.done;
  end

  // Sticky overflow; a clear beats a set in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             r_overflow <= 1'b0;
    else if (clr_overflow) r_overflow <= 1'b0;
    else if (w_drop)       r_overflow <= 1'b1;
  end

  // Serializer FSM: load, shift out one word per accepted handshake, count blocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= SER_IDLE;
      r_sreg        <= '0;
      r_idx         <= '0;
      r_blocks_sent <= '0;
    end else begin
      case (r_state)
        SER_IDLE: begin
          if (!w_empty) begin
            r_sreg  <= w_rd_data;
            r_idx   <= '0;
            r_state <= SER_SEND;
          end
        end
        SER_SEND: begin
          if (bus.dout_ready) begin
            if (r_idx == LAST_IDX) begin
              r_blocks_sent <= r_blocks_sent + 1'b1;
              if (!w_empty) begin
                r_sreg <= w_rd_data;
                r_idx  <= '0;
              end else begin
                r_state <= SER_IDLE;
              end
            end else begin
              r_sreg <= {r_sreg[BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
              r_idx  <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= SER_IDLE;
      endcase
    end
  end

  assign bus.dout       = r_sreg[BLOCK_W-1 -: WORD_W];
  assign bus.dout_valid = (r_state == SER_SEND);
  assign bus.dout_last  = (r_state == SER_SEND) & (r_idx == LAST_IDX);
  assign busy           = ~w_empty | (r_state == SER_SEND);
  assign overflow       = r_overflow;
  assign blocks_sent    = r_blocks_sent;

endmodule

// File: tb/tb_aes256_enc_out_serializer.sv
// Scoreboard bench: expected words are queued when a block is driven and
// compared as the DUT hands words over on valid & ready.
module tb_aes256_enc_out_serializer;
  import aes256_enc_out_serializer_pkg::*;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             clr_overflow;
  logic             busy;
  logic             overflow;
  logic [CNT_W-1:0] blocks_sent;

  aes256_enc_out_serializer_if bus ();

  aes256_enc_out_serializer #(
    .DEPTH (2),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.master),
    .clr_overflow (clr_overflow),
    .busy         (busy),
    .overflow     (overflow),
    .blocks_sent  (blocks_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] sb [$];

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_block(input logic [127:0] data);
    for (int i = 0; i < 4; i++)
      sb.push_back({(i == 3), data[127-32*i -: 32]});
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; done is high for exactly that cycle.
  task automatic pulse(input logic [127:0] data, input bit keep);
    bus.encData = data;
    bus.done    = 1'b1;
    if (keep) push_block(data);
    @(posedge clk);
    #1;
    bus.done = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_idle_timeout", 1'b0, 1'b1);
  endtask

  function automatic logic [127:0] rnd_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: every accepted word must be the next expected one.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset && bus.dout_valid && bus.dout_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("word", bus.dout, e[31:0]);
        chk("last", bus.dout_last, e[32]);
      end
    end
  end

  initial begin
    logic [127:0] d;
    bus.done       = 1'b0;
    bus.encData    = '0;
    bus.dout_ready = 1'b1;
    clr_overflow   = 1'b0;
    reset          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus.dout_valid, 1'b0);
    chk("rst_last", bus.dout_last, 1'b0);
    chk("rst_dout", bus.dout, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_cnt", blocks_sent, 4'd0);
    reset = 1'b0;
    sync();

    // 1: single block, exact latency and word order
    pulse(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1);
    @(negedge clk); chk("t1_valid_T1", bus.dout_valid, 1'b0);
    @(negedge clk); chk("t1_valid_T2", bus.dout_valid, 1'b1);
    chk("t1_w0", bus.dout, 32'h00112233); chk("t1_l0", bus.dout_last, 1'b0);
    @(negedge clk); chk("t1_w1", bus.dout, 32'h44556677); chk("t1_l1", bus.dout_last, 1'b0);
    @(negedge clk); chk("t1_w2", bus.dout, 32'h8899aabb); chk("t1_l2", bus.dout_last, 1'b0);
    @(negedge clk); chk("t1_w3", bus.dout, 32'hccddeeff); chk("t1_l3", bus.dout_last, 1'b1);
    @(negedge clk); chk("t1_valid_end", bus.dout_valid, 1'b0);
    wait_idle();
    chk("t1_cnt", blocks_sent, 4'd1);

    // 2: backpressure on word 1
    sync();
    pulse(128'ha0a1a2a3_b0b1b2b3_c0c1c2c3_d0d1d2d3, 1'b1);
    sync();
    sync();
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", bus.dout_valid, 1'b1);
      chk("t2_hold_dout", bus.dout, 32'hb0b1b2b3);
      chk("t2_hold_last", bus.dout_last, 1'b0);
      sync();
    end
    bus.dout_ready = 1'b1;
    wait_idle();
    chk("t2_cnt", blocks_sent, 4'd2);

    // 3: fill FIFO, overflow, clear, clear-beats-set, back-to-back drain,
    //    push into a full FIFO in the cycle it pops
    sync();
    bus.dout_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pulse(128'h11111111_22222222_33333333_44444444 + 128'(k), k < 3);
      if (k == 2) chk("t3_no_ovf", overflow, 1'b0);
      if (k == 3) chk("t3_ovf", overflow, 1'b1);
      sync();
    end
    clr_overflow = 1'b1;
    sync();
    clr_overflow = 1'b0;
    chk("t3_clr", overflow, 1'b0);
    clr_overflow = 1'b1;
    pulse(128'hdeadbeef_deadbeef_deadbeef_deadbeef, 1'b0);
    clr_overflow = 1'b0;
    chk("t3_clr_wins", overflow, 1'b0);
    bus.dout_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 3) begin
        d = 128'h55555555_66666666_77777777_88888888;
        bus.encData = d;
        bus.done    = 1'b1;
        push_block(d);
      end
      if (k == 4) bus.done = 1'b0;
      @(negedge clk);
      chk("t3_b2b_valid", bus.dout_valid, 1'b1);
      sync();
    end
    chk("t3_full_pushpop_no_ovf", overflow, 1'b0);
    wait_idle();
    chk("t3_cnt", blocks_sent, 4'd6);

    // 4: done held high captures one block
    sync();
    d = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    bus.encData = d;
    bus.done    = 1'b1;
    push_block(d);
    repeat (10) sync();
    bus.done = 1'b0;
    wait_idle();
    chk("t4_cnt", blocks_sent, 4'd7);

    // 5: reset during word 2
    sync();
    pulse(128'hcafef00d_12345678_9abcdef0_0badc0de, 1'b1);
    sync();
    sync();
    sync();
    chk("t5_pre_w2", bus.dout, 32'h9abcdef0);
    reset = 1'b1;
    #1;
    chk("t5_rst_valid", bus.dout_valid, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_cnt", blocks_sent, 4'd0);
    chk("t5_rst_dout", bus.dout, 32'h0);
    sb.delete();
    sync();
    sync();
    reset = 1'b0;
    sync();
    chk("t5_post_busy", busy, 1'b0);
    chk("t5_post_cnt", blocks_sent, 4'd0);
    pulse(128'h01234567_89abcdef_fedcba98_76543210, 1'b1);
    wait_idle();
    chk("t5_fresh_cnt", blocks_sent, 4'd1);

    // 6: counter wrap (CNT_W = 4)
    sync();
    for (int k = 0; k < 14; k++) begin
      pulse(rnd_block(), 1'b1);
      repeat (4) sync();
    end
    wait_idle();
    chk("t6_cnt_max", blocks_sent, 4'hf);
    sync();
    pulse(rnd_block(), 1'b1);
    wait_idle();
    chk("t6_cnt_wrap", blocks_sent, 4'h0);
    chk("t6_ovf", overflow, 1'b0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
